// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32IM-subset decoder feeding the EX control register, with mul hold and GPIO CSR decode
module decode_ctrl_pipe #(
  parameter int          MUL_CYCLES    = 1,
  parameter int          N_GPIO        = 1,
  parameter logic [11:0] CSR_GPIO_BASE = 12'h002,
  parameter logic [11:0] CSR_SW        = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_F,
  input  logic              valid_F,
  input  logic              flush_EX,
  output logic              stall_F,
  output logic              valid_EX,
  output logic              alusrc_EX,
  output logic              regwrite_EX,
  output logic [1:0]        regsel_EX,
  output logic [3:0]        op_EX,
  output logic              zcomp_EX,
  output logic [1:0]        pc_EX,
  output logic [N_GPIO-1:0] gpio_we_EX,
  output logic              illegal_EX
);
  typedef struct packed {
    logic              valid;
    logic              alusrc;
    logic              regwrite;
    logic [1:0]        regsel;
    logic [3:0]        op;
    logic              zcomp;
    logic [1:0]        pc;
    logic [N_GPIO-1:0] gpio_we;
    logic              illegal;
  } ctrl_t;
  localparam logic [3:0] MC = 4'(MUL_CYCLES - 1);
  ctrl_t       d, ex;
  logic        is_mul, ok;
  logic [3:0]  mcnt;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [11:0] csr;
  assign opc = instr_F[6:0];
  assign f3  = instr_F[14:12];
  assign f7  = instr_F[31:25];
  assign csr = instr_F[31:20];
  always_comb begin
    d      = '0;
    is_mul = 1'b0;
    ok     = 1'b1;
    case (opc)
      7'b0110011: begin
        d.regwrite = 1'b1;
        d.regsel   = 2'b10;
        case ({f7, f3})
          {7'h00, 3'b000}: d.op = 4'b0011;
          {7'h00, 3'b001}: d.op = 4'b1000;
          {7'h00, 3'b010}: d.op = 4'b1100;
          {7'h00, 3'b011}: d.op = 4'b1101;
          {7'h00, 3'b100}: d.op = 4'b0010;
          {7'h00, 3'b101}: d.op = 4'b1001;
          {7'h00, 3'b110}: d.op = 4'b0001;
          {7'h00, 3'b111}: d.op = 4'b0000;
          {7'h20, 3'b000}: d.op = 4'b0100;
          {7'h20, 3'b101}: d.op = 4'b1011;
          {7'h01, 3'b000}: begin d.op = 4'b0101; is_mul = 1'b1; end
          {7'h01, 3'b001}: begin d.op = 4'b0110; is_mul = 1'b1; end
          {7'h01, 3'b011}: begin d.op = 4'b0111; is_mul = 1'b1; end
          default:         ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        d.regwrite = 1'b1;
        d.regsel   = 2'b10;
        d.alusrc   = 1'b1;
        case (f3)
          3'b000: d.op = 4'b0011;
          3'b010: d.op = 4'b1100;
          3'b011: d.op = 4'b1101;
          3'b100: d.op = 4'b0010;
          3'b110: d.op = 4'b0001;
          3'b111: d.op = 4'b0000;
          3'b001: begin d.op = 4'b1000; ok = (f7 == 7'h00); end
          default: begin d.op = f7[5] ? 4'b1011 : 4'b1001; ok = (f7 == 7'h00) || (f7 == 7'h20); end
        endcase
      end
      7'b0110111: begin d.regwrite = 1'b1; d.regsel = 2'b01; end
      7'b1101111: begin d.regwrite = 1'b1; d.regsel = 2'b11; d.pc = 2'b10; end
      7'b1100111: begin d.regwrite = 1'b1; d.regsel = 2'b11; d.pc = 2'b11; ok = (f3 == 3'b000); end
      7'b1100011: begin
        d.pc = 2'b01;
        case (f3)
          3'b000:  begin d.op = 4'b0100; d.zcomp = 1'b1; end
          3'b001:  d.op = 4'b0100;
          3'b100:  d.op = 4'b1100;
          3'b101:  begin d.op = 4'b1100; d.zcomp = 1'b1; end
          3'b110:  d.op = 4'b1101;
          3'b111:  begin d.op = 4'b1101; d.zcomp = 1'b1; end
          default: ok = 1'b0;
        endcase
      end
      7'b1110011: begin
        for (int k = 0; k < N_GPIO; k++) d.gpio_we[k] = (csr == CSR_GPIO_BASE + 12'(k));
        d.regwrite = (f3 == 3'b001) && !(|d.gpio_we) && (csr == CSR_SW);
        ok = (f3 == 3'b001) && ((|d.gpio_we) || (csr == CSR_SW));
      end
      default: ok = 1'b0;
    endcase
    d.valid = valid_F;
    if (!ok) begin
      d         = '0;
      d.valid   = valid_F;
      d.illegal = 1'b1;
      is_mul    = 1'b0;
    end
    if (!valid_F) begin
      d      = '0;
      is_mul = 1'b0;
    end
  end
  // mcnt only runs while a mul occupies EX, so it is zero whenever a new load happens
  always_ff @(posedge clk) begin
    if (rst) begin
      ex   <= '0;
      mcnt <= '0;
    end else if (stall_F) begin
      mcnt <= mcnt - 4'd1;
    end else if (flush_EX) begin
      ex <= '0;
    end else begin
      ex   <= d;
      mcnt <= is_mul ? MC : 4'd0;
    end
  end
  assign stall_F     = |mcnt;
  assign valid_EX    = ex.valid;
  assign alusrc_EX   = ex.alusrc;
  assign regwrite_EX = ex.regwrite & ~stall_F;
  assign regsel_EX   = ex.regsel;
  assign op_EX       = ex.op;
  assign zcomp_EX    = ex.zcomp;
  assign pc_EX       = ex.pc;
  assign gpio_we_EX  = ex.gpio_we;
  assign illegal_EX  = ex.illegal;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: instruction-catalog driven checks of decode_ctrl_pipe (MUL_CYCLES=4, N_GPIO=4)
module tb_decode_ctrl_pipe;
  localparam int M = 4;
  localparam logic [31:0] R = 32'h01FF8F80;
  localparam logic [31:0] I = 32'hFFFF8F80;
  localparam logic [31:0] U = 32'hFFFFFF80;
  localparam logic [31:0] C = 32'h000F8F80;
  typedef struct {
    logic [31:0] base;
    logic [31:0] mask;
    logic        as, rw;
    logic [1:0]  rs;
    logic [3:0]  op;
    logic        z;
    logic [1:0]  pc;
    logic [3:0]  g;
    logic        il, mul;
  } cat_t;
  cat_t cat[$];
  logic clk = 1'b0, rst = 1'b1, valid_F = 1'b0, flush_EX = 1'b0;
  logic [31:0] instr_F = '0;
  logic stall_F, valid_EX, alusrc_EX, regwrite_EX, zcomp_EX, illegal_EX;
  logic [1:0] regsel_EX, pc_EX;
  logic [3:0] op_EX, gpio_we_EX;
  int n_tests = 0, n_fail = 0;
  int cur_idx = 0, m_idx = 0, m_hold = 0;
  logic m_live = 1'b0;
  decode_ctrl_pipe #(.MUL_CYCLES(M), .N_GPIO(4), .CSR_GPIO_BASE(12'h002), .CSR_SW(12'h000)) dut (
    .clk(clk), .rst(rst), .instr_F(instr_F), .valid_F(valid_F), .flush_EX(flush_EX),
    .stall_F(stall_F), .valid_EX(valid_EX), .alusrc_EX(alusrc_EX), .regwrite_EX(regwrite_EX),
    .regsel_EX(regsel_EX), .op_EX(op_EX), .zcomp_EX(zcomp_EX), .pc_EX(pc_EX),
    .gpio_we_EX(gpio_we_EX), .illegal_EX(illegal_EX)
  );
  always #5 clk = ~clk;
  task automatic add(input logic [31:0] b, input logic [31:0] m, input logic as, input logic rw,
                     input logic [1:0] rs, input logic [3:0] op, input logic z, input logic [1:0] pc,
                     input logic [3:0] g, input logic il, input logic mul);
    cat_t e;
    e.base = b; e.mask = m; e.as = as; e.rw = rw; e.rs = rs; e.op = op;
    e.z = z; e.pc = pc; e.g = g; e.il = il; e.mul = mul;
    cat.push_back(e);
  endtask
  function automatic logic [17:0] pk(input logic v, input logic a, input logic w, input logic [1:0] s,
                                     input logic [3:0] o, input logic z, input logic [1:0] p,
                                     input logic [3:0] g, input logic il, input logic st);
    return {v, a, w, s, o, z, p, g, il, st};
  endfunction
  function automatic logic [17:0] actual();
    return {valid_EX, alusrc_EX, regwrite_EX, regsel_EX, op_EX, zcomp_EX, pc_EX, gpio_we_EX, illegal_EX, stall_F};
  endfunction
  function automatic logic [17:0] expected();
    cat_t e;
    if (!m_live) return pk(0, 0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 0, m_hold != 0);
    e = cat[m_idx];
    return pk(1, e.as, e.rw && (m_hold == 0), e.rs, e.op, e.z, e.pc, e.g, e.il, m_hold != 0);
  endfunction
  function automatic int find(input logic [31:0] w);
    for (int i = 0; i < cat.size(); i++)
      if ((w & ~cat[i].mask) == cat[i].base) return i;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %05h (v,as,rw,rs,op,z,pc,g,il,st) want %05h instr=%08h", name, $time, act, exp, instr_F);
    end
  endtask
  task automatic drive(input logic [31:0] w);
    instr_F = w;
    cur_idx = find(w);
    if (cur_idx < 0) begin
      $display("FAIL catalog: instr %08h has no entry", w);
      n_fail++;
      cur_idx = 0;
    end
  endtask
  // Reference: EX holds a mul for M cycles in total; otherwise each edge takes F or a bubble
  task automatic tick();
    if (rst) begin
      m_live = 1'b0; m_hold = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (flush_EX || !valid_F) begin
      m_live = 1'b0;
    end else begin
      m_live = 1'b1; m_idx = cur_idx; m_hold = cat[cur_idx].mul ? M - 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("model", actual(), expected());
  endtask
  initial begin
    add(32'h00000033, R, 0, 1, 2'b10, 4'b0011, 0, 2'b00, 4'h0, 0, 0);
    add(32'h40000033, R, 0, 1, 2'b10, 4'b0100, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00001033, R, 0, 1, 2'b10, 4'b1000, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00002033, R, 0, 1, 2'b10, 4'b1100, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00003033, R, 0, 1, 2'b10, 4'b1101, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00004033, R, 0, 1, 2'b10, 4'b0010, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00005033, R, 0, 1, 2'b10, 4'b1001, 0, 2'b00, 4'h0, 0, 0);
    add(32'h40005033, R, 0, 1, 2'b10, 4'b1011, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00006033, R, 0, 1, 2'b10, 4'b0001, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00007033, R, 0, 1, 2'b10, 4'b0000, 0, 2'b00, 4'h0, 0, 0);
    add(32'h02000033, R, 0, 1, 2'b10, 4'b0101, 0, 2'b00, 4'h0, 0, 1);
    add(32'h02001033, R, 0, 1, 2'b10, 4'b0110, 0, 2'b00, 4'h0, 0, 1);
    add(32'h02003033, R, 0, 1, 2'b10, 4'b0111, 0, 2'b00, 4'h0, 0, 1);
    add(32'h00000013, I, 1, 1, 2'b10, 4'b0011, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00002013, I, 1, 1, 2'b10, 4'b1100, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00003013, I, 1, 1, 2'b10, 4'b1101, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00004013, I, 1, 1, 2'b10, 4'b0010, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00006013, I, 1, 1, 2'b10, 4'b0001, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00007013, I, 1, 1, 2'b10, 4'b0000, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00001013, R, 1, 1, 2'b10, 4'b1000, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00005013, R, 1, 1, 2'b10, 4'b1001, 0, 2'b00, 4'h0, 0, 0);
    add(32'h40005013, R, 1, 1, 2'b10, 4'b1011, 0, 2'b00, 4'h0, 0, 0);
    add(32'h00000037, U, 0, 1, 2'b01, 4'b0000, 0, 2'b00, 4'h0, 0, 0);
    add(32'h0000006F, U, 0, 1, 2'b11, 4'b0000, 0, 2'b10, 4'h0, 0, 0);
    add(32'h00000067, I, 0, 1, 2'b11, 4'b0000, 0, 2'b11, 4'h0, 0, 0);
    add(32'h00000063, I, 0, 0, 2'b00, 4'b0100, 1, 2'b01, 4'h0, 0, 0);
    add(32'h00001063, I, 0, 0, 2'b00, 4'b0100, 0, 2'b01, 4'h0, 0, 0);
    add(32'h00004063, I, 0, 0, 2'b00, 4'b1100, 0, 2'b01, 4'h0, 0, 0);
    add(32'h00005063, I, 0, 0, 2'b00, 4'b1100, 1, 2'b01, 4'h0, 0, 0);
    add(32'h00006063, I, 0, 0, 2'b00, 4'b1101, 0, 2'b01, 4'h0, 0, 0);
    add(32'h00007063, I, 0, 0, 2'b00, 4'b1101, 1, 2'b01, 4'h0, 0, 0);
    add(32'h00201073, C, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'b0001, 0, 0);
    add(32'h00301073, C, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'b0010, 0, 0);
    add(32'h00401073, C, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'b0100, 0, 0);
    add(32'h00501073, C, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'b1000, 0, 0);
    add(32'h00001073, C, 0, 1, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 0, 0);
    add(32'hFFFFFFFF, 32'h0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h00000000, 32'h0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h02005013, R, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h40001013, R, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h02002033, R, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h00001067, I, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h00002063, I, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h00601073, C, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h01001073, C, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    add(32'h00005073, C, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 4'h0, 1, 0);
    // reset
    tick();
    tick();
    chk("reset", actual(), 18'h0);
    rst = 1'b0;
    // add x3,x1,x2
    valid_F = 1'b1;
    drive(32'h002081B3);
    tick();
    chk("add", actual(), pk(1, 0, 1, 2'b10, 4'b0011, 0, 2'b00, 4'h0, 0, 0));
    // beq then flushed addi
    drive(32'h00208063);
    tick();
    chk("beq", actual(), pk(1, 0, 0, 2'b00, 4'b0100, 1, 2'b01, 4'h0, 0, 0));
    drive(32'h00100093);
    flush_EX = 1'b1;
    tick();
    chk("flush_bubble", actual(), 18'h0);
    flush_EX = 1'b0;
    tick();
    chk("addi", actual(), pk(1, 1, 1, 2'b10, 4'b0011, 0, 2'b00, 4'h0, 0, 0));
    // mul holds EX for 4 cycles, then add enters
    drive(32'h02208133);
    tick();
    chk("mul_c1", actual(), pk(1, 0, 0, 2'b10, 4'b0101, 0, 2'b00, 4'h0, 0, 1));
    drive(32'h002081B3);
    flush_EX = 1'b1;
    tick();
    chk("mul_c2_flush_ignored", actual(), pk(1, 0, 0, 2'b10, 4'b0101, 0, 2'b00, 4'h0, 0, 1));
    flush_EX = 1'b0;
    tick();
    chk("mul_c3", actual(), pk(1, 0, 0, 2'b10, 4'b0101, 0, 2'b00, 4'h0, 0, 1));
    tick();
    chk("mul_c4", actual(), pk(1, 0, 1, 2'b10, 4'b0101, 0, 2'b00, 4'h0, 0, 0));
    tick();
    chk("mul_next", actual(), pk(1, 0, 1, 2'b10, 4'b0011, 0, 2'b00, 4'h0, 0, 0));
    // CSR decode
    drive(32'h00401073);
    tick();
    chk("csr_gpio2", actual(), pk(1, 0, 0, 2'b00, 4'h0, 0, 2'b00, 4'b0100, 0, 0));
    drive(32'h00001073);
    tick();
    chk("csr_sw", actual(), pk(1, 0, 1, 2'b00, 4'h0, 0, 2'b00, 4'h0, 0, 0));
    drive(32'h01001073);
    tick();
    chk("csr_bad", actual(), pk(1, 0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 1, 0));
    drive(32'hFFFFFFFF);
    tick();
    chk("ill_ones", actual(), pk(1, 0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 1, 0));
    drive(32'h02105093);
    tick();
    chk("ill_srai", actual(), pk(1, 0, 0, 2'b00, 4'h0, 0, 2'b00, 4'h0, 1, 0));
    valid_F = 1'b0;
    tick();
    chk("valid_low", actual(), 18'h0);
    // reset in the middle of a mul stall
    valid_F = 1'b1;
    drive(32'h02208133);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_mul", actual(), 18'h0);
    rst = 1'b0;
    // whole catalog, one entry at a time
    for (int i = 0; i < cat.size(); i++) begin
      drive(cat[i].base | ($urandom & cat[i].mask));
      valid_F = 1'b1;
      flush_EX = 1'b0;
      tick();
      while (m_hold > 0) tick();
    end
    // random traffic
    for (int n = 0; n < 600; n++) begin
      int j;
      j = $urandom_range(0, cat.size() - 1);
      drive(cat[j].base | ($urandom & cat[j].mask));
      valid_F = ($urandom % 4) != 0;
      flush_EX = ($urandom % 5) == 0;
      rst = ($urandom % 64) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
